// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encodings,
// pattern width and the LEDG debug bit map (common with the sequence detector).
package seq_tx_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    PAR  = 2'b10,
    DONE = 2'b11
  } state_e;

  // LEDG debug bit map
  localparam int LEDG_SER     = 0;
  localparam int LEDG_VLD     = 1;
  localparam int LEDG_DONE    = 2;
  localparam int LEDG_PFLG    = 3;
  localparam int LEDG_IDX_LSB = 4;
  localparam int LEDG_IDX_MSB = 6;
  localparam int LEDG_BUSY    = 7;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_f(input logic [WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/seq_tx_start_edge_det.sv
// Rising-edge detector for the level start request: one-cycle pulse on 0->1.
module start_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q_r;

  // Track the previous level every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q_r <= 1'b0;
    end else begin
      level_q_r <= level;
    end
  end

  assign pulse = level & ~level_q_r;

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: latches SW[9:2] on a start edge, shifts it out
// MSB-first on LEDG[0], optionally followed by a parity bit.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [3:3] KEY,
  input  logic [9:0] SW,
  output logic [7:0] LEDG,
  output logic [7:0] LEDR
);

  logic             clk_s;
  logic             rst_n_s;
  logic             start_lvl_s;
  logic [WIDTH-1:0] pat_s;
  logic             start_pulse_s;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] cnt_r;
  logic             par_r;
  logic [7:0]       ledg_s;

  assign clk_s       = KEY[3];
  assign rst_n_s     = SW[1];
  assign start_lvl_s = SW[0];
  assign pat_s       = SW[9:2];

  start_edge_det u_start_edge_det (
    .clk   (clk_s),
    .rst_n (rst_n_s),
    .level (start_lvl_s),
    .pulse (start_pulse_s)
  );

  // State register.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a held start keeps DONE from retriggering.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start_pulse_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (cnt_r == 3'd7) begin
          state_nxt_s = PARITY_EN ? PAR : DONE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      PAR: begin
        state_nxt_s = DONE;
      end
      DONE: begin
        if (start_lvl_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and parity: loaded at start, shifted in SEND.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      shreg_r <= 8'h00;
      cnt_r   <= 3'd0;
      par_r   <= 1'b0;
    end else if ((state_r == IDLE) && start_pulse_s) begin
      shreg_r <= pat_s;
      cnt_r   <= 3'd0;
      par_r   <= parity_f(pat_s, PARITY_ODD);
    end else if (state_r == SEND) begin
      shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
      cnt_r   <= cnt_r + 3'd1;
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
      par_r   <= par_r;
    end
  end

  // Moore output decode from the registers only.
  always_comb begin
    ledg_s = 8'h00;
    case (state_r)
      IDLE: begin
        ledg_s = 8'h00;
      end
      SEND: begin
        ledg_s[LEDG_SER]                  = shreg_r[WIDTH-1];
        ledg_s[LEDG_VLD]                  = 1'b1;
        ledg_s[LEDG_BUSY]                 = 1'b1;
        ledg_s[LEDG_IDX_MSB:LEDG_IDX_LSB] = cnt_r;
      end
      PAR: begin
        ledg_s[LEDG_SER]  = par_r;
        ledg_s[LEDG_VLD]  = 1'b1;
        ledg_s[LEDG_PFLG] = 1'b1;
        ledg_s[LEDG_BUSY] = 1'b1;
      end
      DONE: begin
        ledg_s[LEDG_DONE] = 1'b1;
      end
      default: begin
        ledg_s = 8'h00;
      end
    endcase
  end

  assign LEDG = ledg_s;
  assign LEDR = shreg_r;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: three builds (parity even, parity off,
// parity odd) share clock and switches; a scoreboard per build holds the
// expected LEDG/LEDR for every clock.
module tb_seq_tx;

  typedef struct {
    logic [7:0] ledg;
    logic [7:0] ledr;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    logic       par_even;
  } vec_t;

  logic [3:3] key;
  logic [9:0] sw;
  logic [7:0] ledg_m, ledr_m, ledg_n, ledr_n, ledg_o, ledr_o;

  int checks   = 0;
  int failures = 0;
  int tick_no  = 0;

  exp_t q_m[$];
  exp_t q_n[$];
  exp_t q_o[$];

  vec_t vecs[8];

  seq_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_m (
    .KEY(key), .SW(sw), .LEDG(ledg_m), .LEDR(ledr_m));
  seq_tx #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_n (
    .KEY(key), .SW(sw), .LEDG(ledg_n), .LEDR(ledr_n));
  seq_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_o (
    .KEY(key), .SW(sw), .LEDG(ledg_o), .LEDR(ledr_o));

  initial begin
    key[3] = 1'b0;
    forever #5 key[3] = ~key[3];
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_empty(input string nm);
    checks++;
    failures++;
    $display("FAIL %s scoreboard empty", nm);
  endtask

  task automatic push3(input exp_t m, input exp_t n, input exp_t o);
    q_m.push_back(m);
    q_n.push_back(n);
    q_o.push_back(o);
  endtask

  task automatic push_all(input logic [7:0] ledg, input logic [7:0] ledr);
    exp_t e;
    e.ledg = ledg;
    e.ledr = ledr;
    push3(e, e, e);
  endtask

  // Clock, then compare each build against the head of its scoreboard.
  task automatic check_tick();
    exp_t e;
    @(posedge key[3]);
    #1;
    tick_no++;
    if (q_m.size() == 0) chk_empty($sformatf("t%0d main", tick_no));
    else begin
      e = q_m.pop_front();
      chk($sformatf("t%0d main ledg", tick_no), ledg_m, e.ledg);
      chk($sformatf("t%0d main ledr", tick_no), ledr_m, e.ledr);
    end
    if (q_n.size() == 0) chk_empty($sformatf("t%0d nopar", tick_no));
    else begin
      e = q_n.pop_front();
      chk($sformatf("t%0d nopar ledg", tick_no), ledg_n, e.ledg);
      chk($sformatf("t%0d nopar ledr", tick_no), ledr_n, e.ledr);
    end
    if (q_o.size() == 0) chk_empty($sformatf("t%0d odd", tick_no));
    else begin
      e = q_o.pop_front();
      chk($sformatf("t%0d odd ledg", tick_no), ledg_o, e.ledg);
      chk($sformatf("t%0d odd ledr", tick_no), ledr_o, e.ledr);
    end
  endtask

  // Expected outputs of one frame, from the start edge through DONE.
  task automatic push_frame(input logic [7:0] pat, input logic par_even);
    exp_t m, n, o;
    logic [2:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx    = i[2:0];
      m.ledg = {1'b1, idx, 1'b0, 1'b0, 1'b1, pat[7-i]};
      m.ledr = pat << i;
      push3(m, m, m);
    end
    m.ledg = {1'b1, 3'd0, 1'b1, 1'b0, 1'b1, par_even};
    m.ledr = 8'h00;
    o.ledg = {1'b1, 3'd0, 1'b1, 1'b0, 1'b1, ~par_even};
    o.ledr = 8'h00;
    n.ledg = 8'h04;
    n.ledr = 8'h00;
    push3(m, n, o);
    push_all(8'h04, 8'h00);
  endtask

  task automatic run_frame(input logic [7:0] pat, input logic par_even,
                           input bit disturb, input int hold);
    sw[9:2] = pat;
    sw[0]   = 1'b1;
    push_frame(pat, par_even);
    for (int c = 0; c < 10; c++) begin
      check_tick();
      if (disturb && c == 2) begin
        sw[9:2] = 8'hFF;
        sw[0]   = 1'b0;
      end
      if (disturb && c == 4) sw[0] = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      push_all(8'h04, 8'h00);
      check_tick();
    end
    sw[0] = 1'b0;
    push_all(8'h00, 8'h00);
    check_tick();
  endtask

  initial begin
    vecs[0] = '{pat: 8'b01000101, par_even: 1'b1};
    vecs[1] = '{pat: 8'hA5, par_even: 1'b0};
    vecs[2] = '{pat: 8'h00, par_even: 1'b0};
    vecs[3] = '{pat: 8'hFF, par_even: 1'b0};
    vecs[4] = '{pat: 8'h80, par_even: 1'b1};
    vecs[5] = '{pat: 8'h3C, par_even: 1'b0};
    vecs[6] = '{pat: 8'h01, par_even: 1'b1};
    vecs[7] = '{pat: 8'h7F, par_even: 1'b1};

    // Reset held with random switches.
    sw    = 10'($urandom);
    sw[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_all(8'h00, 8'h00);
      check_tick();
      sw    = 10'($urandom);
      sw[1] = 1'b0;
    end
    sw[0] = 1'b0;
    sw[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_all(8'h00, 8'h00);
      check_tick();
    end

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].pat, vecs[v].par_even, 1'b0, 0);
    end

    // Held start stays in DONE, then a fresh edge starts a new frame.
    run_frame(8'h45, 1'b1, 1'b0, 20);
    run_frame(8'h3C, 1'b0, 1'b0, 0);

    // Pattern and start changes mid-frame are ignored.
    run_frame(8'hA5, 1'b0, 1'b1, 0);

    // Reset during bit 4 clears outputs without a clock edge.
    sw[9:2] = 8'hC3;
    sw[0]   = 1'b1;
    push_frame(8'hC3, 1'b0);
    for (int c = 0; c < 5; c++) check_tick();
    #2;
    sw[1] = 1'b0;
    #1;
    chk("async_rst main ledg", ledg_m, 8'h00);
    chk("async_rst main ledr", ledr_m, 8'h00);
    chk("async_rst nopar ledg", ledg_n, 8'h00);
    chk("async_rst odd ledg", ledg_o, 8'h00);
    q_m.delete();
    q_n.delete();
    q_o.delete();
    sw[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_all(8'h00, 8'h00);
      check_tick();
    end
    sw[1] = 1'b1;
    push_all(8'h00, 8'h00);
    check_tick();
    run_frame(8'h96, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
- Serial pattern transmitter. It is the sending end of the bit-serial link whose receiver is the team's sequence detector.
- On a start request it loads an 8-bit pattern from SW[9:2] and shifts it out MSB-first, one bit per KEY[3] clock, then sends an optional parity bit.
- The serial bit appears on LEDG[0], so it can be fed to the detector's data input.
- Targets the same DE-class board: KEY[3] is the manual clock and SW[1] is the reset switch.

Parameters:
- WIDTH, 8, pattern length in bits. Fixed by SW[9:2]; the bit counter is 3 bits.
- PARITY_EN, 1, when 1 a parity bit follows the data bits; when 0 it is skipped.
- PARITY_ODD, 0, 0 selects even parity (XOR of the data bits); 1 selects odd parity (XNOR of the data bits).

Ports:
- KEY  input  [3:3]  KEY[3] is the clock; all state updates on its rising edge.
- SW  input  [9:0]  SW[1] is the reset, asynchronous and active-low (cleared on negedge SW[1]). SW[0] is the start request (level). SW[9:2] is the pattern, with SW[9] as MSB.
- LEDG  output  [7:0]
  - [0] serial bit
  - [1] bit valid
  - [2] done
  - [3] parity-cycle flag
  - [6:4] bit index
  - [7] busy
- LEDR  output  [7:0]  shift register contents (debug).

Behaviour:
- Reset (SW[1]=0, asynchronous, overrides the clock):
  - state=IDLE; shreg=0; cnt=0; par=0; start_q=0.
  - All LEDG and LEDR bits read 0 while reset is held and after release.
- Outputs are Moore, decoded combinationally from the registers. No output depends directly on SW.
- Start edge: start_q samples SW[0] every clock. start_pulse = SW[0] & ~start_q. It is acted on only in IDLE.
- States: IDLE=2'b00, SEND=2'b01, PAR=2'b10, DONE=2'b11. Any illegal encoding returns to IDLE.
- IDLE:
  - LEDG all 0.
  - On start_pulse: shreg<=SW[9:2]; cnt<=0; par<=reduction-XOR of SW[9:2] (inverted if PARITY_ODD); go to SEND.
- SEND:
  - LEDG[0]=shreg[7]; LEDG[1]=1; LEDG[7]=1; LEDG[6:4]=cnt.
  - Each clock: shreg<=shreg<<1 (zero fill) and cnt<=cnt+1.
  - When cnt==7, go to PAR if PARITY_EN, else DONE. cnt wraps to 0.
  - Exactly 8 SEND cycles.
- PAR:
  - One cycle: LEDG[0]=par; LEDG[1]=1; LEDG[3]=1; LEDG[7]=1.
  - Then go to DONE.
- DONE:
  - LEDG[2]=1; LEDG[0]=0; busy=0.
  - Stay in DONE while SW[0]=1. Go to IDLE on the first clock with SW[0]=0, so a held start never retriggers.
- Latency: the first data bit is visible right after the clock edge that sees start_pulse. The last bit (parity or data bit 0) is visible 8 (or 9) edges later.
- Boundary conditions:
  - SW[9:2] changes during SEND/PAR are ignored (data is latched at start).
  - SW[0] toggling during SEND/PAR is ignored; start_q keeps tracking it.
  - A start edge already high on the cycle DONE->IDLE cannot occur, because leaving DONE requires SW[0]=0.
  - Pattern 0x00 is sent normally; par=0 (even).
  - Reset mid-transfer aborts immediately to IDLE with all outputs 0. There is no partial resume.

Decomposition:
- Shared package/include: state encodings (IDLE, SEND, PAR, DONE), WIDTH, and LEDG bit-index constants (SER, VLD, DONE, PFLG, IDX, BUSY).
  - The detector and this transmitter use the same include for their LEDG debug maps.
- One natural sub-module: start_edge_det.
  - Inputs: clock, async active-low reset, level.
  - Output: the one-cycle rising pulse.
- The remaining shift register, counter and FSM stay in seq_tx.

Test Plan:
1. Reset: hold SW[1]=0 with random SW and KEY toggles -> LEDG=0, LEDR=0. Release with SW[0]=0 -> still all 0 after 3 clocks.
2. Basic frame: SW[9:2]=8'b01000101, raise SW[0], 10 clocks, PARITY_EN=1, even.
   - LEDG[0] sequence 0,1,0,0,0,1,0,1 with LEDG[6:4]=0..7.
   - Then parity 1 with LEDG[3]=1.
   - Then LEDG[2]=1.
3. Held start: keep SW[0]=1 for 20 clocks after DONE -> stays DONE with no second frame. Drop SW[0], then raise it -> a new frame starts.
4. Mid-frame changes: start with 8'hA5. After 3 SEND clocks set SW[9:2]=8'hFF and toggle SW[0] -> the remaining bits still follow A5: 0,0,1,0,1; then parity 0.
5. Reset mid-frame: assert SW[1]=0 during bit 4 -> all outputs 0 immediately without a clock. After release, a new start sends a full frame.
6. PARITY_EN=0 / PARITY_ODD=1 builds with 8'h00:
   - PARITY_EN=0: DONE follows 8 SEND cycles, with no cycle where LEDG[3]=1.
   - PARITY_ODD=1: the parity bit is 1.
